// File: rtl/rv_pkg.sv
// Shared definitions for the F / EX / WB RV32 core.
//   - writeback source select encodings (regsel)
//   - CSR addresses of the memory-mapped I/O registers
//   - base opcodes used by decode
//   - ex_ctrl_t: control bundle handed from decode/EX to WB
package rv_pkg;

  localparam logic [1:0] REGSEL_IO0 = 2'b00;
  localparam logic [1:0] REGSEL_LUI = 2'b01;
  localparam logic [1:0] REGSEL_ALU = 2'b10;
  localparam logic [1:0] REGSEL_RSV = 2'b11;

  localparam logic [11:0] CSR_IO0 = 12'hf00;
  localparam logic [11:0] CSR_IO2 = 12'hf02;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] regsel;
    logic       gpio_we;
  } ex_ctrl_t;

endpackage

// File: rtl/wb_forward.sv
// Dual destination/source comparator for result forwarding.
// Ports:
//   regwrite      in  producing stage will write rd (already x0-gated)
//   rd            in  producing stage destination register
//   rs1, rs2      in  consuming stage source registers
//   fwd_rs1/rs2   out producing result must replace the consumer operand
module wb_forward #(
  parameter int unsigned RADDR = 5
) (
  input  logic             regwrite,
  input  logic [RADDR-1:0] rd,
  input  logic [RADDR-1:0] rs1,
  input  logic [RADDR-1:0] rs2,
  output logic             fwd_rs1,
  output logic             fwd_rs2
);

  always_comb begin
    fwd_rs1 = regwrite && (rd == rs1);
    fwd_rs2 = regwrite && (rd == rs2);
  end

endmodule

// File: rtl/writeback_stage.sv
// EX->WB pipeline register and writeback stage.
// Captures the EX control bundle and datapath values, selects the
// register-file write data, owns the HEX register (io2), samples the
// switches (io0), forwards the WB result to EX and counts retirements.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   valid_EX, stall_EX         EX instruction present / held this cycle
//   regwrite_EX, regsel_EX,
//   GPIO_we                    decoded EX control bundle
//   rd_EX, rs1_EX, rs2_EX      EX register addresses
//   alu_result_EX, imm_U_EX,
//   rs1_data_EX                EX datapath values
//   io0_in                     switch inputs
//   regwrite_WB, rd_WB,
//   writedata_WB               register-file write port
//   io2_out                    HEX display register
//   fwd_rs1, fwd_rs2, fwd_data WB->EX forwarding
//   instret                    retired-instruction counter (wraps)
module writeback_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_EX,
  input  logic             stall_EX,
  input  logic             regwrite_EX,
  input  logic [1:0]       regsel_EX,
  input  logic             GPIO_we,
  input  logic [RADDR-1:0] rd_EX,
  input  logic [RADDR-1:0] rs1_EX,
  input  logic [RADDR-1:0] rs2_EX,
  input  logic [XLEN-1:0]  alu_result_EX,
  input  logic [19:0]      imm_U_EX,
  input  logic [XLEN-1:0]  rs1_data_EX,
  input  logic [XLEN-1:0]  io0_in,
  output logic             regwrite_WB,
  output logic [RADDR-1:0] rd_WB,
  output logic [XLEN-1:0]  writedata_WB,
  output logic [XLEN-1:0]  io2_out,
  output logic             fwd_rs1,
  output logic             fwd_rs2,
  output logic [XLEN-1:0]  fwd_data,
  output logic [XLEN-1:0]  instret
);

  ex_ctrl_t        ctrl_ex;
  logic            take;
  logic            regwrite_gated;
  logic [XLEN-1:0] wdata_sel;
  logic            valid_WB;

  always_comb begin
    ctrl_ex.regwrite = regwrite_EX;
    ctrl_ex.regsel   = regsel_EX;
    ctrl_ex.gpio_we  = GPIO_we;
  end

  assign take = valid_EX && !stall_EX;

  // x0 writes and the reserved source never reach the register file,
  // which also guarantees rd_WB==0 can never forward.
  assign regwrite_gated = ctrl_ex.regwrite
                       && (rd_EX != '0)
                       && (ctrl_ex.regsel != REGSEL_RSV);

  always_comb begin
    wdata_sel = '0;
    unique case (ctrl_ex.regsel)
      REGSEL_IO0: wdata_sel = io0_in;
      REGSEL_LUI: wdata_sel = XLEN'({imm_U_EX, 12'h000});
      REGSEL_ALU: wdata_sel = alu_result_EX;
      default:    wdata_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_WB     <= 1'b0;
      regwrite_WB  <= 1'b0;
      rd_WB        <= '0;
      writedata_WB <= '0;
      io2_out      <= '0;
      instret      <= '0;
    end else begin
      // Retirement is counted on the edge that moves the instruction out of WB.
      if (valid_WB) begin
        instret <= instret + XLEN'(1);
      end
      if (take) begin
        valid_WB     <= 1'b1;
        regwrite_WB  <= regwrite_gated;
        rd_WB        <= rd_EX;
        writedata_WB <= wdata_sel;
      end else begin
        valid_WB     <= 1'b0;
        regwrite_WB  <= 1'b0;
        rd_WB        <= '0;
        writedata_WB <= '0;
      end
      if (take && ctrl_ex.gpio_we) begin
        io2_out <= rs1_data_EX;
      end
    end
  end

  wb_forward #(
    .RADDR(RADDR)
  ) u_fwd (
    .regwrite (regwrite_WB),
    .rd       (rd_WB),
    .rs1      (rs1_EX),
    .rs2      (rs2_EX),
    .fwd_rs1  (fwd_rs1),
    .fwd_rs2  (fwd_rs2)
  );

  assign fwd_data = writedata_WB;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_EX, stall_EX, regwrite_EX, GPIO_we;
  logic [1:0]  regsel_EX;
  logic [4:0]  rd_EX, rs1_EX, rs2_EX;
  logic [31:0] alu_result_EX, rs1_data_EX, io0_in;
  logic [19:0] imm_U_EX;
  logic        regwrite_WB, fwd_rs1, fwd_rs2;
  logic [4:0]  rd_WB;
  logic [31:0] writedata_WB, io2_out, fwd_data, instret;

  always #5 clk = ~clk;

  writeback_stage #(
    .XLEN(32),
    .RADDR(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_EX(valid_EX), .stall_EX(stall_EX),
    .regwrite_EX(regwrite_EX), .regsel_EX(regsel_EX), .GPIO_we(GPIO_we),
    .rd_EX(rd_EX), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .alu_result_EX(alu_result_EX), .imm_U_EX(imm_U_EX),
    .rs1_data_EX(rs1_data_EX), .io0_in(io0_in),
    .regwrite_WB(regwrite_WB), .rd_WB(rd_WB), .writedata_WB(writedata_WB),
    .io2_out(io2_out), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_data(fwd_data), .instret(instret)
  );

  typedef struct {
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] io2;
    logic [31:0] instret;
  } exp_t;

  exp_t exp_q[$];

  // Reference state of the stage
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_io2, m_instret;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic compare_top(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_regwrite"}, {31'd0, regwrite_WB}, {31'd0, e.regwrite});
      chk({tag, "_rd"},       {27'd0, rd_WB},       {27'd0, e.rd});
      chk({tag, "_wdata"},    writedata_WB,         e.data);
      chk({tag, "_io2"},      io2_out,              e.io2);
      chk({tag, "_instret"},  instret,              e.instret);
    end
  endtask

  // Drive one EX cycle, model it, then compare one cycle later.
  task automatic step(input string tag, input logic v, input logic st,
                      input logic rw, input logic [1:0] rs, input logic gw,
                      input logic [4:0] rd, input logic [31:0] alu,
                      input logic [19:0] imm, input logic [31:0] r1d,
                      input logic [31:0] sw);
    logic        tk;
    logic [31:0] d;
    exp_t        e;
    valid_EX = v; stall_EX = st; regwrite_EX = rw; regsel_EX = rs;
    GPIO_we = gw; rd_EX = rd; alu_result_EX = alu; imm_U_EX = imm;
    rs1_data_EX = r1d; io0_in = sw;
    tk = v && !st;
    case (rs)
      2'b00:   d = sw;
      2'b01:   d = {imm, 12'h000};
      2'b10:   d = alu;
      default: d = 32'h0;
    endcase
    if (m_valid) m_instret = m_instret + 32'd1;
    m_valid = tk;
    m_rw    = tk && rw && (rd != 5'd0) && (rs != 2'b11);
    m_rd    = tk ? rd : 5'd0;
    m_data  = tk ? d : 32'h0;
    if (tk && gw) m_io2 = r1d;
    e.regwrite = m_rw; e.rd = m_rd; e.data = m_data;
    e.io2 = m_io2; e.instret = m_instret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_top(tag);
  endtask

  task automatic fwd_check(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    rs1_EX = r1; rs2_EX = r2;
    #1;
    chk({tag, "_fwd1"}, {31'd0, fwd_rs1}, {31'd0, m_rw && (m_rd == r1)});
    chk({tag, "_fwd2"}, {31'd0, fwd_rs2}, {31'd0, m_rw && (m_rd == r2)});
    chk({tag, "_fdata"}, fwd_data, m_data);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    exp_t e;
    rst_n = 1'b0;
    // Active inputs during reset must be ignored
    valid_EX = 1'b1; stall_EX = 1'b0; regwrite_EX = 1'b1; regsel_EX = 2'b00;
    GPIO_we = 1'b1; rd_EX = 5'd9; rs1_data_EX = 32'hDEAD_BEEF;
    io0_in = 32'hFFFF_FFFF;
    for (int i = 0; i < cycles; i++) begin
      m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_data = 32'h0;
      m_io2 = 32'h0; m_instret = 32'h0;
      e.regwrite = 1'b0; e.rd = 5'd0; e.data = 32'h0; e.io2 = 32'h0; e.instret = 32'h0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare_top(tag);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid_EX = 1'b0; stall_EX = 1'b0; regwrite_EX = 1'b0;
    regsel_EX = 2'b00; GPIO_we = 1'b0; rd_EX = '0; rs1_EX = '0; rs2_EX = '0;
    alu_result_EX = '0; imm_U_EX = '0; rs1_data_EX = '0; io0_in = '0;
    m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_data = '0; m_io2 = '0; m_instret = '0;

    do_reset("reset", 2);
    step("idle1", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h0);
    step("idle2", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h0);

    // ALU write, forwarded to rs2
    step("alu", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd5, 32'h1234, 20'h0, 32'h0, 32'h0);
    fwd_check("alu", 5'd0, 5'd5);

    // LUI to x3, then to x0
    step("lui", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 5'd3, 32'h0, 20'hABCDE, 32'h0, 32'h0);
    fwd_check("lui", 5'd3, 5'd4);
    step("lui_x0", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 32'h0, 20'hABCDE, 32'h0, 32'h0);
    fwd_check("lui_x0", 5'd0, 5'd0);

    // CSR io0 read, then io2 write
    step("io0", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 5'd7, 32'h0, 20'h0, 32'h0, 32'h0000_00A5);
    step("io2", 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 5'd8, 32'h77, 20'h0, 32'hA5, 32'h0);

    // Stall with GPIO_we: bubble, no HEX write, no retirement afterwards
    step("stall", 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 5'd9, 32'h99, 20'h0, 32'h55, 32'h0);
    step("post_stall", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h0);

    // GPIO_we and regwrite together: both act
    step("both", 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 5'd10, 32'hCAFE, 20'h0, 32'h3C3C_0001, 32'h0);

    // Reserved source: data zero, write suppressed
    step("rsv", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 5'd11, 32'hFFFF, 20'h1, 32'h0, 32'h1);

    // Back-to-back writes to the same rd: newest value forwards
    step("b2b_a", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd12, 32'h1111, 20'h0, 32'h0, 32'h0);
    step("b2b_b", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd12, 32'h2222, 20'h0, 32'h0, 32'h0);
    fwd_check("b2b", 5'd12, 5'd12);

    // Valid but GPIO_we with valid_EX=0: nothing captured, HEX holds
    step("novalid", 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 5'd13, 32'h5, 20'h0, 32'h6, 32'h0);

    // Reset mid-stream discards the instruction in WB
    step("pre_rst", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd14, 32'h4444, 20'h0, 32'h0, 32'h0);
    do_reset("mid_reset", 1);
    step("after_rst", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h0);

    // instret wrap: preload all-ones while WB holds a bubble
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    m_instret = 32'hFFFF_FFFF;
    step("wrap_i1", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd1, 32'h1, 20'h0, 32'h0, 32'h0);
    chk("wrap_hold", instret, 32'hFFFF_FFFF);
    step("wrap_i2", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd2, 32'h2, 20'h0, 32'h0, 32'h0);
    chk("wrap_zero", instret, 32'h0);
    step("wrap_end", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0, 32'h0);
    chk("wrap_one", instret, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
